// File: rtl/vending_credit_sequencer.sv
// Credit sequencer for the soda machine: accumulates coins, sells against a price,
// holds the dispenser for a fixed time and then pays change out one coin per pulse.
module vending_credit_sequencer #(
   parameter int W           = 8,
   parameter int COIN_UNIT   = 5,
   parameter int DISP_CYCLES = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         coin_valid,
   input  logic [W-1:0] coin_value,
   input  logic         sel_valid,
   input  logic [W-1:0] price,
   input  logic         cancel,
   output logic         dispense,
   output logic         change_pulse,
   output logic         coin_reject,
   output logic         sel_denied,
   output logic         busy,
   output logic [W-1:0] credit,
   output logic [2:0]   state_dbg
);

   typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_DISP, S_CHG_A, S_CHG_B} state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [W-1:0]  UNIT  = W'(COIN_UNIT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [DW-1:0] DLAST = DW'(DISP_CYCLES - 1);

   state_t        state_q, state_d;
   logic [W-1:0]  credit_q, credit_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] disp_cnt_q, disp_cnt_d;
   logic          dispense_q, dispense_d;
   logic          change_q, change_d;
   logic          reject_q, reject_d;
   logic          denied_q, denied_d;
   logic          busy_q, busy_d;
   logic [W:0]    sum;
   logic          tick, to_change, to_rest;

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      timer_d    = timer_q;
      disp_cnt_d = disp_cnt_q;
      dispense_d = 1'b0;
      change_d   = 1'b0;
      reject_d   = 1'b0;
      denied_d   = 1'b0;
      tick       = 1'b0;
      to_change  = 1'b0;
      to_rest    = 1'b0;
      sum        = {1'b0, credit_q} + {1'b0, coin_value};

      case (state_q)
         S_IDLE: begin
            denied_d = sel_valid;
            if (coin_valid && coin_value != '0) begin
               credit_d = coin_value;
               timer_d  = '0;
               state_d  = S_CREDIT;
            end
         end
         S_CREDIT: begin
            // Priority cancel > sel_valid > coin_valid; losers are refused.
            if (cancel) begin
               reject_d  = coin_valid;
               denied_d  = sel_valid;
               to_change = 1'b1;
            end else if (sel_valid) begin
               reject_d = coin_valid;
               if (credit_q >= price) begin
                  credit_d   = credit_q - price;
                  disp_cnt_d = DLAST;
                  dispense_d = 1'b1;
                  state_d    = S_DISP;
               end else begin
                  denied_d = 1'b1;
                  tick     = 1'b1;
               end
            end else if (coin_valid && !sum[W]) begin
               credit_d = sum[W-1:0];
               timer_d  = '0;
            end else begin
               reject_d = coin_valid;
               tick     = 1'b1;
            end
         end
         S_DISP: begin
            reject_d = coin_valid;
            denied_d = sel_valid;
            if (disp_cnt_q == '0) begin
               if (credit_q >= UNIT) to_change = 1'b1;
               else                  to_rest   = 1'b1;
            end else begin
               disp_cnt_d = disp_cnt_q - 1'b1;
               dispense_d = 1'b1;
            end
         end
         S_CHG_A: begin
            reject_d = coin_valid;
            denied_d = sel_valid;
            state_d  = S_CHG_B;
         end
         S_CHG_B: begin
            reject_d = coin_valid;
            denied_d = sel_valid;
            if (credit_q >= UNIT) to_change = 1'b1;
            else                  to_rest   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (tick) begin
         if (timer_q == TLAST) to_change = 1'b1;
         else                  timer_d   = timer_q + 1'b1;
      end

      // Entering the payout loop with less than one coin unit spends a single quiet cycle.
      if (to_change) begin
         if (credit_q >= UNIT) begin
            credit_d = credit_q - UNIT;
            change_d = 1'b1;
            state_d  = S_CHG_A;
         end else begin
            state_d = S_CHG_B;
         end
      end

      if (to_rest) begin
         state_d = (credit_q != '0) ? S_CREDIT : S_IDLE;
         timer_d = '0;
      end

      busy_d = (state_d == S_DISP) || (state_d == S_CHG_A) || (state_d == S_CHG_B);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         credit_q   <= '0;
         timer_q    <= '0;
         disp_cnt_q <= '0;
         dispense_q <= 1'b0;
         change_q   <= 1'b0;
         reject_q   <= 1'b0;
         denied_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         timer_q    <= timer_d;
         disp_cnt_q <= disp_cnt_d;
         dispense_q <= dispense_d;
         change_q   <= change_d;
         reject_q   <= reject_d;
         denied_q   <= denied_d;
         busy_q     <= busy_d;
      end
   end

   assign dispense     = dispense_q;
   assign change_pulse = change_q;
   assign coin_reject  = reject_q;
   assign sel_denied   = denied_q;
   assign busy         = busy_q;
   assign credit       = credit_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_vending_credit_sequencer.sv
// Bench for vending_credit_sequencer: directed scenarios plus random traffic, every
// cycle compared against a script-based reference model of the machine's rules.
module tb_vending_credit_sequencer;

   localparam int W  = 8;
   localparam int U  = 5;
   localparam int D  = 4;
   localparam int TO = 20;
   localparam int EW = W + 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         coin_valid = 1'b0;
   logic [W-1:0] coin_value = '0;
   logic         sel_valid = 1'b0;
   logic [W-1:0] price = '0;
   logic         cancel = 1'b0;
   logic         dispense, change_pulse, coin_reject, sel_denied, busy;
   logic [W-1:0] credit;
   logic [2:0]   state_dbg;

   always #5 clk = ~clk;

   vending_credit_sequencer #(
      .W(W), .COIN_UNIT(U), .DISP_CYCLES(D), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .sel_valid(sel_valid), .price(price), .cancel(cancel),
      .dispense(dispense), .change_pulse(change_pulse),
      .coin_reject(coin_reject), .sel_denied(sel_denied),
      .busy(busy), .credit(credit), .state_dbg(state_dbg)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: outside a busy period it applies the credit rules directly;
   // a purchase, cancel or timeout writes the whole busy period as a script of
   // per-cycle outputs {dispense, change_pulse, busy, credit} that is replayed.
   logic [EW-1:0] exp_q[$];
   int            m_credit = 0;
   int            m_idle   = 0;
   logic          e_disp, e_chg, e_rej, e_den, e_busy;
   logic [W-1:0]  e_cred;
   int            n_disp, n_chg;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void push_change(input int c);
      int cc = c;
      if (cc < U) exp_q.push_back({1'b0, 1'b0, 1'b1, W'(cc)});
      while (cc >= U) begin
         cc -= U;
         exp_q.push_back({1'b0, 1'b1, 1'b1, W'(cc)});
         exp_q.push_back({1'b0, 1'b0, 1'b1, W'(cc)});
      end
      exp_q.push_back({1'b0, 1'b0, 1'b0, W'(cc)});
   endfunction

   function automatic void push_purchase(input int c);
      for (int i = 0; i < D; i++) exp_q.push_back({1'b1, 1'b0, 1'b1, W'(c)});
      if (c >= U) push_change(c);
      else        exp_q.push_back({1'b0, 1'b0, 1'b0, W'(c)});
   endfunction

   function automatic void take();
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      {e_disp, e_chg, e_busy, e_cred} = e;
      m_credit = int'(e[W-1:0]);
      m_idle   = 0;
   endfunction

   function automatic void quiet_outs();
      e_disp = 1'b0;
      e_chg  = 1'b0;
      e_busy = 1'b0;
      e_cred = W'(m_credit);
   endfunction

   function automatic void advance_idle();
      m_idle++;
      if (m_idle == TO) begin
         push_change(m_credit);
         take();
      end else begin
         quiet_outs();
      end
   endfunction

   function automatic void model_step(input logic r, input logic cv, input logic [W-1:0] val,
                                      input logic sv, input logic [W-1:0] pr, input logic ca);
      e_rej = 1'b0;
      e_den = 1'b0;
      if (r) begin
         exp_q.delete();
         m_credit = 0;
         m_idle   = 0;
         quiet_outs();
      end else if (exp_q.size() > 0) begin
         e_rej = cv;
         e_den = sv;
         take();
      end else if (m_credit == 0) begin
         e_den = sv;
         if (cv && val != 0) begin
            m_credit = int'(val);
            m_idle   = 0;
         end
         quiet_outs();
      end else if (ca) begin
         e_rej = cv;
         e_den = sv;
         push_change(m_credit);
         take();
      end else if (sv) begin
         e_rej = cv;
         if (m_credit >= int'(pr)) begin
            push_purchase(m_credit - int'(pr));
            take();
         end else begin
            e_den = 1'b1;
            advance_idle();
         end
      end else if (cv && (m_credit + int'(val)) < (1 << W)) begin
         m_credit += int'(val);
         m_idle   = 0;
         quiet_outs();
      end else begin
         e_rej = cv;
         advance_idle();
      end
   endfunction

   // One clock: drive on the falling edge, step the model at the rising edge, compare 1ns later.
   task automatic cycle(input logic r, input logic cv, input logic [W-1:0] val,
                        input logic sv, input logic [W-1:0] pr, input logic ca);
      @(negedge clk);
      rst        = r;
      coin_valid = cv;
      coin_value = val;
      sel_valid  = sv;
      price      = pr;
      cancel     = ca;
      @(posedge clk);
      model_step(r, cv, val, sv, pr, ca);
      #1;
      check_val("outs", {dispense, change_pulse, coin_reject, sel_denied, busy},
                {e_disp, e_chg, e_rej, e_den, e_busy});
      check_val("credit", credit, e_cred);
      n_disp += int'(dispense);
      n_chg  += int'(change_pulse);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic coin(input int v);
      cycle(1'b0, 1'b1, W'(v), 1'b0, '0, 1'b0);
   endtask

   task automatic sel(input int p);
      cycle(1'b0, 1'b0, '0, 1'b1, W'(p), 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      n_disp = 0;
      n_chg  = 0;
   endtask

   logic [W-1:0] coin_tab [7] = '{8'd1, 8'd2, 8'd5, 8'd10, 8'd25, 8'd50, 8'd100};

   initial begin
      n_disp = 0;
      n_chg  = 0;

      // Reset held two cycles with coins arriving; a zero coin in idle is ignored.
      cycle(1'b1, 1'b1, 8'd10, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b1, 8'd10, 1'b0, '0, 1'b0);
      check_val("rst_credit", credit, 0);
      check_val("rst_outs", {dispense, change_pulse, coin_reject, sel_denied, busy}, 0);
      check_val("rst_state", state_dbg, 0);
      coin(0);
      check_val("zero_coin_credit", credit, 0);

      // Purchase with change.
      n_disp = 0; n_chg = 0;
      coin(10); coin(10); coin(10);
      sel(25);
      check_val("purch_credit_after_sel", credit, 5);
      check_val("purch_busy", busy, 1);
      idle(10);
      check_val("purch_disp_cycles", n_disp, D);
      check_val("purch_pulses", n_chg, 1);
      check_val("purch_end_credit", credit, 0);
      check_val("purch_end_busy", busy, 0);

      // Denied selection, then cancel, then selection in idle.
      n_disp = 0;
      coin(10);
      sel(25);
      check_val("deny_pulse", sel_denied, 1);
      check_val("deny_credit", credit, 10);
      idle(2);
      check_val("deny_no_dispense", n_disp, 0);
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(6);
      check_val("deny_refund_credit", credit, 0);
      sel(5);
      check_val("idle_sel_denied", sel_denied, 1);

      // Cancel with remainder, coin during payout is refused.
      coin(25); coin(2);
      n_chg = 0;
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(2);
      coin(5);
      check_val("chg_coin_reject", coin_reject, 1);
      idle(10);
      check_val("cancel_pulses", n_chg, 5);
      check_val("cancel_remainder", credit, 2);
      check_val("cancel_not_busy", busy, 0);
      do_reset();

      // Overflow refusal, then cancel and coin in the same cycle.
      coin(100); coin(100); coin(50);
      coin(10);
      check_val("ovf_reject", coin_reject, 1);
      check_val("ovf_credit", credit, 250);
      cycle(1'b0, 1'b1, 8'd10, 1'b0, '0, 1'b1);
      check_val("simul_reject", coin_reject, 1);
      check_val("simul_pulse", change_pulse, 1);
      idle(105);
      check_val("ovf_refund_pulses", n_chg, 50);
      check_val("ovf_refund_credit", credit, 0);

      // Idle timeout refunds 15 as three coins.
      coin(10); coin(5);
      n_chg = 0;
      idle(TO + 10);
      check_val("timeout_pulses", n_chg, 3);
      check_val("timeout_credit", credit, 0);

      // Reset in the middle of dispensing.
      coin(10); coin(10);
      sel(5);
      idle(1);
      do_reset();
      check_val("abort_dispense", dispense, 0);
      check_val("abort_credit", credit, 0);
      idle(10);
      check_val("abort_no_pulses", n_chg + n_disp, 0);

      // Random traffic with quiet stretches long enough to trigger timeouts.
      for (int seg = 0; seg < 8; seg++) begin
         for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) == 0),
                  coin_tab[$urandom_range(0, 6)],
                  ($urandom_range(0, 9) == 0),
                  W'($urandom_range(0, 80)),
                  ($urandom_range(0, 29) == 0));
         end
         idle(TO + 5);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
